// File: rtl/pipeline_pkg.sv
// Shared definitions for the memory-wait instruction pipeline chain.
package pipeline_pkg;
  localparam logic [31:0] NOP_INSTR = 32'hE320_F000;
  typedef logic [31:0] instr_t;
endpackage

// File: rtl/pipeline_slot.sv
// One chain slot: data/valid register with load enable; reset and flush return it to NOP.
module pipeline_slot #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic              i_src_valid,
  input  logic [DATA_W-1:0] i_src_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid
);
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  always_ff @(posedge clk) begin
    if (i_rst || i_flush) begin
      r_data  <= NOP_VALUE;
      r_valid <= 1'b0;
    end else if (i_load) begin
      // an empty source writes NOP so stale words never linger in a bubble
      r_valid <= i_src_valid;
      r_data  <= i_src_valid ? i_src_data : NOP_VALUE;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
endmodule

// File: rtl/memory_wait_pipeline_chain.sv
// Elastic DEPTH-slot instruction chain feeding the memory-wait stage; bubbles
// collapse under back-pressure and flush squashes every slot to NOP.
module memory_wait_pipeline_chain
  import pipeline_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 2,
  parameter logic [DATA_W-1:0] NOP_VALUE = NOP_INSTR[DATA_W-1:0]
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            instr_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_W-1:0]            instr_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  w_valid;
  logic [DEPTH-1:0]  w_move;
  logic [DEPTH-1:0]  w_load;
  logic [DEPTH-1:0]  w_src_valid;
  logic [DATA_W-1:0] w_data     [DEPTH];
  logic [DATA_W-1:0] w_src_data [DEPTH];

  // move ripples from the output slot back toward the input side
  always_comb begin
    w_move = '0;
    w_move[DEPTH-1] = w_valid[DEPTH-1] & out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      w_move[k] = w_valid[k] & (~w_valid[k+1] | w_move[k+1]);
    end
  end

  assign w_load = ~w_valid | w_move;

  always_comb begin
    w_src_valid[0] = in_valid;
    w_src_data[0]  = instr_in;
    for (int k = 1; k < DEPTH; k++) begin
      w_src_valid[k] = w_valid[k-1];
      w_src_data[k]  = w_data[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    pipeline_slot #(
      .DATA_W    (DATA_W),
      .NOP_VALUE (NOP_VALUE)
    ) u_slot (
      .clk         (clk),
      .i_rst       (rst),
      .i_flush     (flush),
      .i_load      (w_load[k]),
      .i_src_valid (w_src_valid[k]),
      .i_src_data  (w_src_data[k]),
      .o_data      (w_data[k]),
      .o_valid     (w_valid[k])
    );
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(w_valid[k]);
    end
  end

  assign in_ready  = w_load[0] & ~flush;
  assign instr_out = w_data[DEPTH-1];
  assign out_valid = w_valid[DEPTH-1];
endmodule

// File: tb/tb_memory_wait_pipeline_chain.sv
// Bench for the instruction chain: directed scenarios plus randomized traffic
// checked against a timestamped queue model on three configurations.
module tb_memory_wait_pipeline_chain;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr_in = '0;
  logic        iv = 1'b0, ordy = 1'b0, fl = 1'b0;
  int          sel = 0;
  int          n_checks = 0, n_fail = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  logic        rdy3, ov3, rdy4, ov4, rdy1, ov1;
  logic [31:0] out3, out4;
  logic [15:0] out1;
  logic [1:0]  occ3;
  logic [2:0]  occ4;
  logic [0:0]  occ1;

  memory_wait_pipeline_chain #(.DATA_W(32), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .instr_in(instr_in), .in_valid(iv && sel == 0),
    .in_ready(rdy3), .instr_out(out3), .out_valid(ov3),
    .out_ready(ordy && sel == 0), .flush(fl && sel == 0), .occupancy(occ3));

  memory_wait_pipeline_chain #(.DATA_W(32), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .instr_in(instr_in), .in_valid(iv && sel == 1),
    .in_ready(rdy4), .instr_out(out4), .out_valid(ov4),
    .out_ready(ordy && sel == 1), .flush(fl && sel == 1), .occupancy(occ4));

  memory_wait_pipeline_chain #(.DATA_W(16), .DEPTH(1), .NOP_VALUE(16'h0000)) u_d1 (
    .clk(clk), .rst(rst), .instr_in(instr_in[15:0]), .in_valid(iv && sel == 2),
    .in_ready(rdy1), .instr_out(out1), .out_valid(ov1),
    .out_ready(ordy && sel == 2), .flush(fl && sel == 2), .occupancy(occ1));

  logic        m_rdy, m_ov;
  logic [31:0] m_out;
  logic [3:0]  m_occ;

  always_comb begin
    m_rdy = rdy3; m_ov = ov3; m_out = out3; m_occ = 4'(occ3);
    case (sel)
      1: begin m_rdy = rdy4; m_ov = ov4; m_out = out4; m_occ = 4'(occ4); end
      2: begin m_rdy = rdy1; m_ov = ov1; m_out = 32'(out1); m_occ = 4'(occ1); end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    iv = 1'b0; ordy = 1'b0; fl = 1'b0; instr_in = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] d;
    int          acc;
  } ent_t;

  // Each entry reaches the output DEPTH cycles after acceptance unless an
  // older entry is still ahead of it; the queue head is therefore exact.
  task automatic run_random(input int s, input int cycles, input bit use_flush);
    ent_t        q[$];
    int          depth;
    logic [31:0] nop, mask;
    bit          exp_rdy, exp_ov;
    sel = s;
    depth = (s == 0) ? 3 : (s == 1) ? 4 : 1;
    nop   = (s == 2) ? 32'h0 : 32'hE320F000;
    mask  = (s == 2) ? 32'h0000FFFF : 32'hFFFFFFFF;
    do_reset();
    for (int i = 0; i < cycles; i++) begin
      iv       = ($urandom_range(0, 3) != 0);
      instr_in = $urandom & mask;
      ordy     = $urandom_range(0, 1) == 1;
      fl       = use_flush && ($urandom_range(0, 24) == 0);
      #1;
      exp_rdy = !fl && ((q.size() < depth) || ordy);
      exp_ov  = (q.size() > 0) && (cyc - q[0].acc >= depth);
      chk("rnd_occ", 32'(m_occ), q.size());
      chk("rnd_in_ready", 32'(m_rdy), 32'(exp_rdy));
      chk("rnd_out_valid", 32'(m_ov), 32'(exp_ov));
      if (exp_ov) chk("rnd_data", m_out, q[0].d);
      else        chk("rnd_nop", m_out, nop);
      if (exp_ov && ordy) void'(q.pop_front());
      if (fl) q.delete();
      else if (iv && exp_rdy) q.push_back('{d: instr_in, acc: cyc});
      @(posedge clk);
      #1;
      cyc++;
    end
    idle_inputs();
  endtask

  initial begin
    // reset with an instruction being offered
    sel = 0;
    idle_inputs();
    rst = 1'b1; iv = 1'b1; instr_in = 32'hE3A01005;
    tick(); tick();
    rst = 1'b0; iv = 1'b0;
    #1;
    chk("rst_out_valid", 32'(ov3), 32'h0);
    chk("rst_instr_out", out3, 32'hE320F000);
    chk("rst_occ", 32'(occ3), 32'h0);
    chk("rst_in_ready", 32'(rdy3), 32'h1);
    chk("rst_d1_instr_out", 32'(out1), 32'h0);
    tick();

    // latency and streaming on DEPTH=3
    ordy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      iv = (i < 3); instr_in = i + 1;
      #1;
      chk("lat_in_ready", 32'(rdy3), 32'h1);
      chk("lat_out_valid", 32'(ov3), 32'(i >= 3 && i <= 5));
      if (i >= 3 && i <= 5) chk("lat_data", out3, i - 2);
      tick();
    end
    idle_inputs();

    // back-pressure on DEPTH=3
    for (int i = 0; i < 5; i++) begin
      iv = 1'b1; instr_in = 32'h10 + ((i < 3) ? i : 3);
      #1;
      chk("bp_in_ready", 32'(rdy3), 32'(i < 3));
      tick();
    end
    #1;
    chk("bp_occ_full", 32'(occ3), 32'h3);
    chk("bp_head", out3, 32'h10);
    ordy = 1'b1; instr_in = 32'h13;
    #1;
    chk("bp_ready_same_cycle", 32'(rdy3), 32'h1);
    tick();
    ordy = 1'b0; iv = 1'b0;
    #1;
    chk("bp_occ_steady", 32'(occ3), 32'h3);
    chk("bp_next_head", out3, 32'h11);
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_drain_valid", 32'(ov3), 32'(i < 3));
      if (i < 3) chk("bp_drain_data", out3, 32'h11 + i);
      tick();
    end
    idle_inputs();

    // bubble collapse on DEPTH=4
    sel = 1;
    for (int i = 0; i < 7; i++) begin
      iv = (i == 0 || i == 3);
      instr_in = (i == 0) ? 32'hAAAA0001 : 32'hBBBB0002;
      tick();
      iv = 1'b0;
    end
    #1;
    chk("bub_occ", 32'(occ4), 32'h2);
    chk("bub_head", out4, 32'hAAAA0001);
    ordy = 1'b1;
    tick();
    #1;
    chk("bub_second_valid", 32'(ov4), 32'h1);
    chk("bub_second_data", out4, 32'hBBBB0002);
    tick();
    #1;
    chk("bub_empty", 32'(occ4), 32'h0);
    idle_inputs();

    // flush of a full DEPTH=3 chain
    sel = 0;
    for (int i = 0; i < 5; i++) begin
      iv = (i < 3); instr_in = 32'h20 + i;
      tick();
    end
    #1;
    chk("fl_full", 32'(occ3), 32'h3);
    fl = 1'b1; iv = 1'b1; instr_in = 32'h99;
    #1;
    chk("fl_in_ready", 32'(rdy3), 32'h0);
    tick();
    fl = 1'b0; iv = 1'b0;
    #1;
    chk("fl_occ", 32'(occ3), 32'h0);
    chk("fl_out_valid", 32'(ov3), 32'h0);
    chk("fl_instr_out", out3, 32'hE320F000);
    chk("fl_in_ready_after", 32'(rdy3), 32'h1);
    ordy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("fl_no_emit", 32'(ov3), 32'h0);
      tick();
    end
    idle_inputs();

    // randomized traffic against the queue model
    run_random(2, 200, 1'b0);
    run_random(0, 300, 1'b1);
    run_random(1, 300, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
